uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_cmd_parser                                                 |
// | Purpose  : Parses 'W'/'R' register frames from a UART byte stream and      |
// |            answers with ACK/NAK or read-back bytes on the TX FIFO.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_cmd_parser #(
  parameter int REG_DEPTH     = 16,
  parameter int REG_WIDTH     = 4,
  parameter int LITTLE_ENDIAN = 0,
  parameter int TIMEOUT       = 65535
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic [7:0]                   i_data,
  input  logic                         i_dv,
  output logic [$clog2(REG_DEPTH)-1:0] o_reg_addr,
  output logic [8*REG_WIDTH-1:0]       o_reg_wdata,
  output logic                         o_reg_wen,
  output logic                         o_reg_ren,
  input  logic [8*REG_WIDTH-1:0]       i_reg_rdata,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_wen,
  input  logic                         i_tx_full,
  output logic                         o_err,
  output logic                         o_busy
);

  localparam int c_AW = $clog2(REG_DEPTH);
  localparam int c_DW = 8 * REG_WIDTH;
  localparam int c_BW = $clog2(REG_WIDTH + 1);
  localparam int c_TW = $clog2(TIMEOUT + 1);
  localparam logic [c_BW-1:0] c_LAST      = c_BW'(REG_WIDTH - 1);
  localparam logic [c_TW-1:0] c_TOUT_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [7:0] c_CMD_WR = 8'h57;
  localparam logic [7:0] c_CMD_RD = 8'h52;
  localparam logic [7:0] c_ACK    = 8'h06;
  localparam logic [7:0] c_NAK    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_EXEC_WR = 3'd3,
    S_EXEC_RD = 3'd4,
    S_LOAD    = 3'd5,
    S_SEND    = 3'd6,
    S_ACK     = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cmd_wr;
  logic [c_AW-1:0]   r_addr;
  logic [c_DW-1:0]   r_wdata;
  logic [c_DW-1:0]   r_shift;
  logic [c_BW-1:0]   r_bcnt;
  logic [c_TW-1:0]   r_tcnt;
  logic [7:0]        r_ack_byte;
  logic              r_wen;
  logic              r_ren;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_tx_wen;
  logic              w_timeout;
  logic              w_addr_bad;
  logic              w_in_exec;
  logic [c_DW-1:0]   w_wdata_shift;
  logic [c_DW-1:0]   w_shift_nxt;
  logic [7:0]        w_tx_byte;

  // Byte ordering on the wire is shared by the write assembly and the read-back shifter.
  generate
    if (REG_WIDTH == 1) begin : g_single_byte
      assign w_wdata_shift = i_data;
      assign w_shift_nxt   = '0;
      assign w_tx_byte     = r_shift;
    end else if (LITTLE_ENDIAN != 0) begin : g_lsb_first
      assign w_wdata_shift = {i_data, r_wdata[c_DW-1:8]};
      assign w_shift_nxt   = {8'h00, r_shift[c_DW-1:8]};
      assign w_tx_byte     = r_shift[7:0];
    end else begin : g_msb_first
      assign w_wdata_shift = {r_wdata[c_DW-9:0], i_data};
      assign w_shift_nxt   = {r_shift[c_DW-9:0], 8'h00};
      assign w_tx_byte     = r_shift[c_DW-1:c_DW-8];
    end
  endgenerate

  assign w_addr_bad = (32'(i_data) >= REG_DEPTH);
  assign w_timeout  = !i_dv && (r_tcnt == c_TOUT_LAST);
  assign w_in_exec  = (r_state == S_EXEC_WR) || (r_state == S_EXEC_RD) ||
                      (r_state == S_LOAD) || (r_state == S_SEND) || (r_state == S_ACK);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_tx_wen    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dv) begin
          if ((i_data == c_CMD_WR) || (i_data == c_CMD_RD)) w_state_nxt = S_ADDR;
          else                                               w_err_nxt   = 1'b1;
        end
      end
      S_ADDR: begin
        if (i_dv) begin
          if (w_addr_bad)    w_state_nxt = S_ACK;
          else if (r_cmd_wr) w_state_nxt = S_DATA;
          else               w_state_nxt = S_EXEC_RD;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DATA: begin
        if (i_dv) begin
          if (r_bcnt == c_LAST) w_state_nxt = S_EXEC_WR;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      S_EXEC_WR: w_state_nxt = S_ACK;
      S_EXEC_RD: w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_SEND;
      S_SEND: begin
        w_tx_wen = !i_tx_full;
        if (!i_tx_full && (r_bcnt == c_LAST)) w_state_nxt = S_IDLE;
      end
      S_ACK: begin
        w_tx_wen = !i_tx_full;
        if (!i_tx_full) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Bytes arriving while a command is executing or responding are lost.
    if (i_dv && w_in_exec) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cmd_wr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_tcnt     <= '0;
      r_ack_byte <= 8'h00;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wen <= (w_state_nxt == S_EXEC_WR);
      r_ren <= (w_state_nxt == S_EXEC_RD);
      r_err <= w_err_nxt;
      if (i_dv)                                         r_tcnt <= '0;
      else if ((r_state == S_ADDR) || (r_state == S_DATA)) r_tcnt <= r_tcnt + 1'b1;
      case (r_state)
        S_IDLE: if (i_dv) r_cmd_wr <= (i_data == c_CMD_WR);
        S_ADDR: begin
          if (i_dv) begin
            r_addr     <= i_data[c_AW-1:0];
            r_bcnt     <= '0;
            r_ack_byte <= c_NAK;
          end
        end
        S_DATA: begin
          if (i_dv) begin
            r_wdata <= w_wdata_shift;
            r_bcnt  <= r_bcnt + 1'b1;
          end
        end
        S_EXEC_WR: r_ack_byte <= c_ACK;
        S_LOAD: begin
          r_shift <= i_reg_rdata;
          r_bcnt  <= '0;
        end
        S_SEND: begin
          if (!i_tx_full) begin
            r_shift <= w_shift_nxt;
            r_bcnt  <= r_bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_wen   = r_wen;
  assign o_reg_ren   = r_ren;
  assign o_tx_data   = (r_state == S_ACK) ? r_ack_byte : w_tx_byte;
  assign o_tx_wen    = w_tx_wen;
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
